// File: rtl/router_pkt_reader.sv
// Router output-port reader: drains header/payload/parity packets from a port FIFO
// and streams payload bytes through a 2-entry output buffer with per-packet status.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | wait for vld_out, issue the single header read
// HDR     | header byte arriving; latch length, address check, parity seed
// PAYLOAD | fetch payload bytes into the output buffer under occupancy limit
// PARITY  | fetch and compare the parity byte
// CLOSE   | one-cycle pkt_done with status, bump error counter
module router_pkt_reader #(
    parameter logic [1:0] PORT_ID = 2'd0,
    parameter logic [5:0] TIMEOUT = 6'd24
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       vld_out,
    input  logic [7:0] data_out,
    output logic       read_enb,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    input  logic       out_ready,
    output logic       pkt_done,
    output logic       par_err,
    output logic       addr_err,
    output logic       trunc_err,
    output logic [5:0] pkt_len,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_PARITY,
        S_CLOSE
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       rd_pend;
    logic       rd_req;
    logic [5:0] req_cnt;
    logic [5:0] cap_cnt;
    logic [5:0] tmr;
    logic       par_req;
    logic [7:0] run_par;
    logic       f_par;
    logic       f_addr;
    logic       f_trunc;
    logic [5:0] len_q;
    logic [7:0] err_q;

    logic [7:0] buf_data [2];
    logic [1:0] buf_sop;
    logic [1:0] buf_eop;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] occ;

    logic       active;
    logic       tmo;
    logic       last_pay;
    logic       pay_rd;
    logic       push;
    logic       pop;

    // A read issued last cycle means data_out carries a FIFO byte this cycle.
    assign active   = (state == S_HDR) || (state == S_PAYLOAD) || (state == S_PARITY);
    assign tmo      = active && !rd_pend && (tmr <= 6'd1);
    assign last_pay = (cap_cnt + 6'd1) == len_q;
    assign pay_rd   = vld_out && ((occ + {1'b0, rd_pend}) < 2'd2)
                      && (req_cnt < len_q) && !tmo;
    assign push     = (state == S_PAYLOAD) && rd_pend;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (vld_out) begin
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (rd_pend) begin
                    state_nxt = (data_out[7:2] == 6'd0) ? S_PARITY : S_PAYLOAD;
                end else if (tmo) begin
                    state_nxt = S_CLOSE;
                end
            end
            S_PAYLOAD: begin
                if (rd_pend && last_pay) begin
                    state_nxt = S_PARITY;
                end else if (tmo) begin
                    state_nxt = S_CLOSE;
                end
            end
            S_PARITY: begin
                if (rd_pend || tmo) begin
                    state_nxt = S_CLOSE;
                end
            end
            S_CLOSE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_req = 1'b0;
        case (state)
            S_IDLE:    rd_req = vld_out;
            S_PAYLOAD: rd_req = pay_rd;
            S_PARITY:  rd_req = vld_out && !par_req && !tmo;
            default:   rd_req = 1'b0;
        endcase
        // Gated by resetn so the FIFO sees no read while reset is held.
        read_enb  = rd_req && resetn;
        pkt_done  = (state == S_CLOSE);
        par_err   = pkt_done && f_par;
        addr_err  = pkt_done && f_addr;
        trunc_err = pkt_done && f_trunc;
    end

    assign pkt_len = len_q;
    assign err_cnt = err_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_pend <= 1'b0;
            req_cnt <= 6'd0;
            cap_cnt <= 6'd0;
            tmr     <= 6'd0;
            par_req <= 1'b0;
            run_par <= 8'd0;
            f_par   <= 1'b0;
            f_addr  <= 1'b0;
            f_trunc <= 1'b0;
            len_q   <= 6'd0;
            err_q   <= 8'd0;
        end else begin
            rd_pend <= rd_req;
            if (active) begin
                if (rd_pend) begin
                    tmr <= TIMEOUT;
                end else if (tmr != 6'd0) begin
                    tmr <= tmr - 6'd1;
                end
            end
            if (tmo) begin
                f_trunc <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    req_cnt <= 6'd0;
                    cap_cnt <= 6'd0;
                    par_req <= 1'b0;
                    tmr     <= TIMEOUT;
                    f_par   <= 1'b0;
                    f_addr  <= 1'b0;
                    f_trunc <= 1'b0;
                end
                S_HDR: begin
                    if (rd_pend) begin
                        len_q   <= data_out[7:2];
                        // A zero-length header never reports an address error.
                        f_addr  <= (data_out[1:0] != PORT_ID) && (data_out[7:2] != 6'd0);
                        run_par <= data_out;
                    end
                end
                S_PAYLOAD: begin
                    if (rd_req) begin
                        req_cnt <= req_cnt + 6'd1;
                    end
                    if (rd_pend) begin
                        cap_cnt <= cap_cnt + 6'd1;
                        run_par <= run_par ^ data_out;
                    end
                end
                S_PARITY: begin
                    if (rd_req) begin
                        par_req <= 1'b1;
                    end
                    if (rd_pend) begin
                        f_par <= (data_out != run_par);
                    end
                end
                S_CLOSE: begin
                    if ((f_par || f_addr || f_trunc) && (err_q != 8'hFF)) begin
                        err_q <= err_q + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output buffer; the read-side occupancy limit guarantees a push never hits a full buffer.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            buf_data[0] <= 8'd0;
            buf_data[1] <= 8'd0;
            buf_sop     <= 2'b00;
            buf_eop     <= 2'b00;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= data_out;
                buf_sop[wr_ptr]  <= (cap_cnt == 6'd0);
                buf_eop[wr_ptr]  <= last_pay;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign out_valid = (occ != 2'd0);
    assign out_data  = out_valid ? buf_data[rd_ptr] : 8'd0;
    assign out_sop   = out_valid && buf_sop[rd_ptr];
    assign out_eop   = out_valid && buf_eop[rd_ptr];

endmodule

// File: doc/router_pkt_reader.md
ROUTER_PKT_READER -- requirements
Module: router_pkt_reader

Interface
REQ-001 SHALL have parameter PORT_ID, default 2'd0: router output port this reader drains; compared to header address bits.
REQ-002 SHALL have parameter TIMEOUT, default 6'd24: max idle cycles mid-packet before abort; SHALL be < 30 (FIFO soft-reset window).
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 vld_out  input  1  router port FIFO non-empty.
REQ-006 data_out  input  8  router port FIFO read data, valid the cycle after read_enb sampled high.
REQ-007 read_enb  output  1  FIFO read request, one byte per asserted cycle.
REQ-008 out_data  output  8  payload byte to consumer.
REQ-009 out_valid / out_sop / out_eop  output  1 each  byte valid, first payload byte, last payload byte.
REQ-010 out_ready  input  1  consumer accepts byte when out_valid && out_ready.
REQ-011 pkt_done  output  1  one-cycle pulse at packet close.
REQ-012 par_err / addr_err / trunc_err  output  1 each  status, valid only with pkt_done.
REQ-013 pkt_len  output  6  payload length of current/last packet (header[7:2]).
REQ-014 err_cnt  output  8  saturating count of packets closed with any error.

Function
REQ-015 Packet format SHALL be: header (len=[7:2], addr=[1:0]), len payload bytes, parity byte = XOR of header and all payload bytes; len=0 treated as addr_err-free, zero-payload packet.
REQ-016 States SHALL be IDLE, HDR, PAYLOAD, PARITY, CLOSE.
REQ-017 IDLE: vld_out=1 -> assert read_enb one cycle, go HDR; no other read in IDLE.
REQ-018 HDR: no read issued; on header capture latch pkt_len, addr_err = (addr != PORT_ID), init running parity = header; len>0 -> PAYLOAD, len=0 -> PARITY.
REQ-019 PAYLOAD: read_enb = vld_out && (buffer occupancy + reads in flight) < 2 && payload requested < len; each captured byte XORed into parity and pushed to buffer with sop (first) / eop (len-th) flags; after len-th byte captured -> PARITY.
REQ-020 PARITY: read_enb asserted once when vld_out; on capture par_err = (byte != running parity) -> CLOSE.
REQ-021 CLOSE: pulse pkt_done with status for exactly one cycle, increment err_cnt (saturate at 255) if any error, -> IDLE next cycle.
REQ-022 Output buffer SHALL be 2-entry FIFO; out_valid = non-empty; pop on out_valid && out_ready; out_data/sop/eop stable while out_valid && !out_ready.
REQ-023 Captured payload SHALL never be dropped; the occupancy rule of REQ-019 guarantees space.
REQ-024 Timeout: in HDR/PAYLOAD/PARITY, idle counter increments each cycle no byte is captured, clears on capture; reaching TIMEOUT -> trunc_err=1, -> CLOSE; any buffered bytes still drain; if eop not yet emitted, last buffered byte SHALL NOT gain eop.
REQ-025 Backpressure SHALL NOT stall state transitions into CLOSE beyond buffer drain need; CLOSE may precede final buffer pop.
REQ-026 Latency: header read at cycle t, header captured t+1, first payload read t+2 earliest, first out_valid t+4 earliest.
REQ-027 Back-to-back packets: IDLE may issue next header read the cycle after CLOSE regardless of buffer occupancy.

Reset
REQ-028 resetn=0 SHALL immediately force: state IDLE, read_enb=0, out_valid/out_sop/out_eop=0, out_data=0, pkt_done=0, all error flags 0, pkt_len=0, err_cnt=0, buffer empty, counters 0.
REQ-029 Reset mid-packet SHALL discard partial packet; no pkt_done emitted for it.

Verification
REQ-030 Header 8'h0C (len 3, addr 0), payload 11,22,33, parity 8'h0C^11^22^33, out_ready=1, PORT_ID=0 -> 3 bytes out, sop on 11, eop on 33, pkt_done with all errors 0.
REQ-031 Same packet, parity byte 8'hFF -> payload delivered intact, pkt_done with par_err=1, err_cnt 0->1.
REQ-032 Header 8'h15 (len 5, addr 1), PORT_ID=0, correct parity -> addr_err=1, par_err=0, payload still delivered.
REQ-033 len 8 packet, out_ready=0 for 10 cycles mid-packet -> read_enb never issued with occupancy+inflight >= 2, no byte lost, order preserved after release.
REQ-034 vld_out drops after 2 of 4 payload bytes for 24 cycles -> trunc_err=1 with pkt_done, 2 bytes out, no eop flagged.
REQ-035 resetn pulsed low mid-PAYLOAD -> all outputs zero within same cycle; next valid packet after release processed correctly.
